// File: rtl/cache_lookup_ctrl_pkg.sv
// Shared definitions for the multi-level cache lookup controller.
// Holds the controller state encoding, the response level codes, the
// fill-strobe masks used when promoting a line into the upper levels,
// and the saturating increment used by the hit counters.
package cache_lookup_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PROBE    = 3'd1,
        ST_EVAL     = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_FILL     = 3'd4,
        ST_RESP     = 3'd5
    } state_e;

    // Response level codes (also index the hit counters)
    localparam logic [1:0] LVL_L1  = 2'd0;
    localparam logic [1:0] LVL_L2  = 2'd1;
    localparam logic [1:0] LVL_L3  = 2'd2;
    localparam logic [1:0] LVL_MEM = 2'd3;

    // Fill strobes: bit0=L1, bit1=L2, bit2=L3
    localparam logic [2:0] FILL_NONE   = 3'b000;
    localparam logic [2:0] FILL_L2_HIT = 3'b001;
    localparam logic [2:0] FILL_L3_HIT = 3'b011;
    localparam logic [2:0] FILL_MEM    = 3'b111;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Increment that sticks at the maximum instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cache_lookup_ctrl_sat_counter16.sv
// 16-bit saturating event counter.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (clears count)
//   srst  - synchronous clear
//   inc   - count one event this cycle
//   count - current value, holds at 16'hFFFF once reached
module sat_counter16
    import cache_lookup_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] cnt_r;

    // Counter register with saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if (srst) begin
            cnt_r <= 16'd0;
        end else if (inc) begin
            cnt_r <= sat_inc16(cnt_r);
        end
    end

    assign count = cnt_r;

endmodule

// File: rtl/cache_lookup_ctrl.sv
// Lookup controller for a three-level cache hierarchy backed by memory.
// A request is probed against L1/L2/L3 in parallel; the highest-priority
// hit answers (promoting the line upward on L2/L3 hits), a full miss is
// fetched from memory with a bounded wait, and each successful response
// is counted per level.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   req_valid/req_ready/req_addr    - request handshake
//   rsp_valid/rsp_data/rsp_level/rsp_err - one-cycle response
//   lookup_en/lookup_addr           - probe to all cache levels
//   l1/l2/l3_hit, l1/l2/l3_data     - level results, valid the cycle after the probe
//   fill_en/fill_data               - line promotion strobes
//   mem_req/mem_ack/mem_data        - backing memory handshake
//   busy                            - transaction in flight
//   hit_cnt                         - {mem, L3, L2, L1} 16-bit saturating hit counts
module cache_lookup_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic [1:0]        rsp_level,
    output logic              rsp_err,
    output logic              lookup_en,
    output logic [ADDR_W-1:0] lookup_addr,
    input  logic              l1_hit,
    input  logic              l2_hit,
    input  logic              l3_hit,
    input  logic [WORD_W-1:0] l1_data,
    input  logic [WORD_W-1:0] l2_data,
    input  logic [WORD_W-1:0] l3_data,
    output logic [2:0]        fill_en,
    output logic [WORD_W-1:0] fill_data,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_data,
    output logic              busy,
    output logic [63:0]       hit_cnt
);
    import cache_lookup_ctrl_pkg::*;

    // Wait count value of the last MEM_WAIT cycle allowed before giving up
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e              state_r;
    state_e              next_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [1:0]          lvl_r;
    logic [7:0]          wait_cnt_r;
    logic                ready_r;
    logic                busy_r;
    logic                lookup_en_r;
    logic                mem_req_r;
    logic [2:0]          fill_en_r;
    logic [WORD_W-1:0]   fill_data_r;
    logic                rsp_valid_r;
    logic [WORD_W-1:0]   rsp_data_r;
    logic [1:0]          rsp_level_r;
    logic                rsp_err_r;

    logic [2:0]          fill_mask_s;
    logic [WORD_W-1:0]   cap_data_s;
    logic [1:0]          cap_lvl_s;
    logic                cap_err_s;
    logic [7:0]          wait_cnt_nxt_s;
    logic [3:0]          cnt_inc_s;
    logic [15:0]         cnt_l1_s;
    logic [15:0]         cnt_l2_s;
    logic [15:0]         cnt_l3_s;
    logic [15:0]         cnt_mem_s;

    // Next-state decode plus the data/level/error to capture on the transition.
    // cap_data_s defaults to the staged fill word so FILL hands it to RESP.
    always_comb begin
        next_s         = state_r;
        fill_mask_s    = FILL_NONE;
        cap_data_s     = fill_data_r;
        cap_lvl_s      = lvl_r;
        cap_err_s      = 1'b0;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && ready_r) begin
                    next_s = ST_PROBE;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_PROBE: begin
                next_s = ST_EVAL;
            end
            ST_EVAL: begin
                wait_cnt_nxt_s = 8'd0;
                if (l1_hit) begin
                    next_s     = ST_RESP;
                    cap_data_s = l1_data;
                    cap_lvl_s  = LVL_L1;
                end else if (l2_hit) begin
                    next_s      = ST_FILL;
                    fill_mask_s = FILL_L2_HIT;
                    cap_data_s  = l2_data;
                    cap_lvl_s   = LVL_L2;
                end else if (l3_hit) begin
                    next_s      = ST_FILL;
                    fill_mask_s = FILL_L3_HIT;
                    cap_data_s  = l3_data;
                    cap_lvl_s   = LVL_L3;
                end else begin
                    next_s    = ST_MEM_WAIT;
                    cap_lvl_s = LVL_MEM;
                end
            end
            ST_MEM_WAIT: begin
                // An ack in the final allowed cycle still wins over the timeout
                if (mem_ack) begin
                    next_s      = ST_FILL;
                    fill_mask_s = FILL_MEM;
                    cap_data_s  = mem_data;
                    cap_lvl_s   = LVL_MEM;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    next_s         = ST_RESP;
                    cap_data_s     = '0;
                    cap_lvl_s      = LVL_MEM;
                    cap_err_s      = 1'b1;
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end else begin
                    next_s         = ST_MEM_WAIT;
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end
            end
            ST_FILL: begin
                next_s = ST_RESP;
            end
            ST_RESP: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state
    // so each one is high for exactly the cycle spent in its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            lvl_r       <= LVL_L1;
            wait_cnt_r  <= 8'd0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            lookup_en_r <= 1'b0;
            mem_req_r   <= 1'b0;
            fill_en_r   <= FILL_NONE;
            fill_data_r <= '0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_level_r <= LVL_L1;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= next_s;
            lvl_r       <= cap_lvl_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            ready_r     <= (next_s == ST_IDLE);
            busy_r      <= (next_s != ST_IDLE);
            lookup_en_r <= (next_s == ST_PROBE);
            mem_req_r   <= (next_s == ST_MEM_WAIT);
            rsp_valid_r <= (next_s == ST_RESP);
            fill_en_r   <= (next_s == ST_FILL) ? fill_mask_s : FILL_NONE;
            if ((state_r == ST_IDLE) && req_valid && ready_r) begin
                addr_r <= req_addr;
            end
            if (next_s == ST_FILL) begin
                fill_data_r <= cap_data_s;
            end
            if (next_s == ST_RESP) begin
                rsp_data_r  <= cap_data_s;
                rsp_level_r <= cap_lvl_s;
                rsp_err_r   <= cap_err_s;
            end else begin
                rsp_err_r   <= 1'b0;
            end
        end
    end

    // Count successful responses per level during the RESP cycle
    always_comb begin
        cnt_inc_s = 4'b0000;
        if (rsp_valid_r && !rsp_err_r) begin
            cnt_inc_s[0] = (rsp_level_r == LVL_L1);
            cnt_inc_s[1] = (rsp_level_r == LVL_L2);
            cnt_inc_s[2] = (rsp_level_r == LVL_L3);
            cnt_inc_s[3] = (rsp_level_r == LVL_MEM);
        end else begin
            cnt_inc_s = 4'b0000;
        end
    end

    sat_counter16 u_cnt_l1 (
        .clk(clk), .rst_n(rst_n), .srst(1'b0), .inc(cnt_inc_s[0]), .count(cnt_l1_s)
    );
    sat_counter16 u_cnt_l2 (
        .clk(clk), .rst_n(rst_n), .srst(1'b0), .inc(cnt_inc_s[1]), .count(cnt_l2_s)
    );
    sat_counter16 u_cnt_l3 (
        .clk(clk), .rst_n(rst_n), .srst(1'b0), .inc(cnt_inc_s[2]), .count(cnt_l3_s)
    );
    sat_counter16 u_cnt_mem (
        .clk(clk), .rst_n(rst_n), .srst(1'b0), .inc(cnt_inc_s[3]), .count(cnt_mem_s)
    );

    assign req_ready   = ready_r;
    assign busy        = busy_r;
    assign lookup_en   = lookup_en_r;
    assign lookup_addr = addr_r;
    assign mem_req     = mem_req_r;
    assign fill_en     = fill_en_r;
    assign fill_data   = fill_data_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_level   = rsp_level_r;
    assign rsp_err     = rsp_err_r;
    assign hit_cnt     = {cnt_mem_s, cnt_l3_s, cnt_l2_s, cnt_l1_s};

endmodule
